store_unit: RTL and testbench
=============================

# store_unit

Memory write engine for the 6502 core: the write-side counterpart to instruction fetch. Execute issues one request per instruction: a single-byte store (STA/STX/STY) to a resolved effective address, or a 1-3 byte stack push (PHA/PHP, JSR, BRK/IRQ/NMI). The unit sequences the bus writes one byte per cycle, computes stack addresses and returns the updated stack pointer. It owns the memory write strobe and drives nothing on reads.

## Interface
- REG_WIDTH, 8, data/register width
- ADDR_WIDTH, 16, address bus width
- STACK_BASE, 16'h0100, page-1 stack base added to SP
- phi1  in  1  clock, all state changes on rising edge
- reset_n  in  1  reset, synchronous, active-low
- req_valid  in  1  request present
- req_ready  out  1  unit can accept; high only in IDLE
- req_kind  in  2  00 STORE, 01 PUSH1, 10 PUSH2 (PC), 11 PUSH3 (PC then P)
- req_addr  in  ADDR_WIDTH  effective address (STORE only)
- req_data  in  REG_WIDTH  byte for STORE/PUSH1; status P for PUSH3
- req_pc  in  ADDR_WIDTH  return address for PUSH2/PUSH3
- sp_in  in  REG_WIDTH  current SP
- mem_addr  out  ADDR_WIDTH  write address
- mem_data  out  REG_WIDTH  write data
- mem_we  out  1  write strobe; memory samples addr/data on the edge ending a cycle with mem_we=1
- sp_out  out  REG_WIDTH  new SP, valid while sp_we=1
- sp_we  out  1  SP update strobe, one cycle
- done  out  1  one-cycle pulse marking final write of a request
- busy  out  1  inverse of req_ready

## Operation
- States: IDLE, W_STORE, W_PCH, W_PCL, W_P, W_B1 (PUSH1 byte). All outputs registered.
- Accept: rising edge with reset_n=1, state IDLE, req_valid=1. On that edge, latch req_kind, req_addr, req_data, req_pc, sp_in (as sp_reg) and enter the first write state:
  - STORE -> W_STORE
  - PUSH1 -> W_B1
  - PUSH2/PUSH3 -> W_PCH
- req_valid while not IDLE is ignored. Requesters hold requests until accepted.
- W_STORE: mem_addr=req_addr, mem_data=req_data, mem_we=1, done=1, sp_we=0. Next state IDLE.
- W_B1: mem_addr=STACK_BASE+sp_reg, mem_data=req_data, mem_we=1, sp_out=sp_reg-1, sp_we=1, done=1. Next state IDLE.
- W_PCH: mem_addr=STACK_BASE+sp_reg, mem_data=req_pc[15:8]. Next state W_PCL.
- W_PCL: mem_addr=STACK_BASE+(sp_reg-1), mem_data=req_pc[7:0].
  - PUSH2: sp_out=sp_reg-2, sp_we=1, done=1. Next state IDLE.
  - PUSH3: next state W_P.
- W_P: mem_addr=STACK_BASE+(sp_reg-2), mem_data=req_data, sp_out=sp_reg-3, sp_we=1, done=1. Next state IDLE.
- SP arithmetic is 8-bit modulo 256. The stack address high byte is always STACK_BASE[15:8]; it never carries into page 2 or borrows into page 0.
- Outside write states: mem_we=0, sp_we=0, done=0. mem_addr/mem_data hold their last values.

## Timing
- Reset: reset_n=0 at an edge forces state IDLE, mem_we=0, sp_we=0, done=0, mem_addr=0, mem_data=0, sp_out=0, req_ready=1 and busy=0 from the next cycle.
- Requests are not accepted on an edge where reset_n=0.
- Reset mid-request aborts it. Bytes already written stay in memory, no further writes occur, and no sp_we or done is issued.
- Latency from the accept edge: first mem_we cycle is the cycle immediately after.
  - STORE: 1 write cycle.
  - PUSH1: 1 write cycle.
  - PUSH2: 2 write cycles.
  - PUSH3: 3 write cycles.
- done, sp_we and the final mem_we coincide in the same cycle.
- req_ready returns high in the cycle after done. Minimum request spacing is (bytes+1) cycles.
- sp_in is sampled only at accept. Later changes do not affect the request in flight.

## Test plan
- Reset: hold reset_n=0 for 2 edges with req_valid=1 -> no mem_we; after release, req_ready=1, all strobes 0, mem_addr=0.
- STORE: req_addr=16'h0234, req_data=8'hA5 -> one cycle after accept, mem_we=1, mem_addr=0234, mem_data=A5, done=1, sp_we=0; req_ready=1 the following cycle.
- PUSH3 (BRK): sp_in=FF, req_pc=16'hC123, req_data=8'h34 -> three consecutive writes:
  - 01FF<=C1
  - 01FE<=23
  - 01FD<=34
  - sp_out=FC with sp_we and done on the third write.
- SP wrap: PUSH3 with sp_in=01, req_pc=16'h1234, P=8'h5A -> writes 0101<=12, 0100<=34, 01FF<=5A; sp_out=FE.
- Busy ignore: during PUSH2 (sp_in=80, req_pc=16'hABCD), present STORE at cycle 1 -> writes are 0180<=AB then 017F<=CD, sp_out=7E; the STORE is accepted only after req_ready returns.
- Abort: PUSH2 with sp_in=40, reset_n=0 on the edge after the first write -> only 0140 is written, no sp_we or done, state IDLE.

Source files
------------

// File: rtl/store_unit.sv
// Store/push write engine for the 6502 core: sequences one-byte-per-cycle bus
// writes for STORE and 1-3 byte stack pushes, and returns the updated SP.
module store_unit #(
    parameter int                    REG_WIDTH  = 8,
    parameter int                    ADDR_WIDTH = 16,
    parameter logic [ADDR_WIDTH-1:0] STACK_BASE = 16'h0100
) (
    input  logic                  phi1,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [1:0]            req_kind,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [REG_WIDTH-1:0]  req_data,
    input  logic [ADDR_WIDTH-1:0] req_pc,
    input  logic [REG_WIDTH-1:0]  sp_in,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [REG_WIDTH-1:0]  mem_data,
    output logic                  mem_we,
    output logic [REG_WIDTH-1:0]  sp_out,
    output logic                  sp_we,
    output logic                  done,
    output logic                  busy
);

    localparam logic [1:0] KIND_STORE = 2'b00;
    localparam logic [1:0] KIND_PUSH1 = 2'b01;
    localparam logic [1:0] KIND_PUSH2 = 2'b10;
    localparam logic [1:0] KIND_PUSH3 = 2'b11;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        W_STORE = 3'd1,
        W_PCH   = 3'd2,
        W_PCL   = 3'd3,
        W_P     = 3'd4,
        W_B1    = 3'd5
    } state_t;

    // Stack lives in one page: the offset wraps within the low byte, never carrying into the high byte.
    function automatic logic [ADDR_WIDTH-1:0] stack_addr(input logic [REG_WIDTH-1:0] sp,
                                                         input logic [REG_WIDTH-1:0] offs);
        logic [REG_WIDTH-1:0] lo;
        lo = STACK_BASE[REG_WIDTH-1:0] + sp - offs;
        return {STACK_BASE[ADDR_WIDTH-1:REG_WIDTH], lo};
    endfunction

    state_t                state_r, state_n_s;
    logic [1:0]            kind_r, kind_n_s;
    logic [ADDR_WIDTH-1:0] addr_r, addr_n_s;
    logic [REG_WIDTH-1:0]  data_r, data_n_s;
    logic [ADDR_WIDTH-1:0] pc_r, pc_n_s;
    logic [REG_WIDTH-1:0]  sp_r, sp_n_s;

    logic [ADDR_WIDTH-1:0] mem_addr_r, mem_addr_n_s;
    logic [REG_WIDTH-1:0]  mem_data_r, mem_data_n_s;
    logic                  mem_we_r, mem_we_n_s;
    logic [REG_WIDTH-1:0]  sp_out_r, sp_out_n_s;
    logic                  sp_we_r, sp_we_n_s;
    logic                  done_r, done_n_s;
    logic                  ready_r;

    // Next state and request latching; accept only from IDLE.
    always_comb begin
        state_n_s = state_r;
        kind_n_s  = kind_r;
        addr_n_s  = addr_r;
        data_n_s  = data_r;
        pc_n_s    = pc_r;
        sp_n_s    = sp_r;
        case (state_r)
            IDLE: begin
                if (req_valid) begin
                    kind_n_s = req_kind;
                    addr_n_s = req_addr;
                    data_n_s = req_data;
                    pc_n_s   = req_pc;
                    sp_n_s   = sp_in;
                    case (req_kind)
                        KIND_STORE: state_n_s = W_STORE;
                        KIND_PUSH1: state_n_s = W_B1;
                        KIND_PUSH2: state_n_s = W_PCH;
                        KIND_PUSH3: state_n_s = W_PCH;
                        default:    state_n_s = IDLE;
                    endcase
                end else begin
                    state_n_s = IDLE;
                end
            end
            W_STORE: state_n_s = IDLE;
            W_B1:    state_n_s = IDLE;
            W_PCH:   state_n_s = W_PCL;
            W_PCL: begin
                if (kind_r == KIND_PUSH3) begin
                    state_n_s = W_P;
                end else begin
                    state_n_s = IDLE;
                end
            end
            W_P:     state_n_s = IDLE;
            default: state_n_s = IDLE;
        endcase
    end

    // Outputs are decoded from the state being entered so they can be registered alongside it.
    always_comb begin
        mem_addr_n_s = mem_addr_r;
        mem_data_n_s = mem_data_r;
        mem_we_n_s   = 1'b0;
        sp_out_n_s   = sp_out_r;
        sp_we_n_s    = 1'b0;
        done_n_s     = 1'b0;
        case (state_n_s)
            W_STORE: begin
                mem_addr_n_s = addr_n_s;
                mem_data_n_s = data_n_s;
                mem_we_n_s   = 1'b1;
                done_n_s     = 1'b1;
            end
            W_B1: begin
                mem_addr_n_s = stack_addr(sp_n_s, REG_WIDTH'(0));
                mem_data_n_s = data_n_s;
                mem_we_n_s   = 1'b1;
                sp_out_n_s   = sp_n_s - REG_WIDTH'(1);
                sp_we_n_s    = 1'b1;
                done_n_s     = 1'b1;
            end
            W_PCH: begin
                mem_addr_n_s = stack_addr(sp_n_s, REG_WIDTH'(0));
                mem_data_n_s = pc_n_s[ADDR_WIDTH-1 -: REG_WIDTH];
                mem_we_n_s   = 1'b1;
            end
            W_PCL: begin
                mem_addr_n_s = stack_addr(sp_n_s, REG_WIDTH'(1));
                mem_data_n_s = pc_n_s[REG_WIDTH-1:0];
                mem_we_n_s   = 1'b1;
                if (kind_n_s == KIND_PUSH2) begin
                    sp_out_n_s = sp_n_s - REG_WIDTH'(2);
                    sp_we_n_s  = 1'b1;
                    done_n_s   = 1'b1;
                end else begin
                    sp_we_n_s  = 1'b0;
                    done_n_s   = 1'b0;
                end
            end
            W_P: begin
                mem_addr_n_s = stack_addr(sp_n_s, REG_WIDTH'(2));
                mem_data_n_s = data_n_s;
                mem_we_n_s   = 1'b1;
                sp_out_n_s   = sp_n_s - REG_WIDTH'(3);
                sp_we_n_s    = 1'b1;
                done_n_s     = 1'b1;
            end
            default: begin
                mem_we_n_s = 1'b0;
            end
        endcase
    end

    // State, request and output registers with synchronous reset.
    always_ff @(posedge phi1) begin
        if (!reset_n) begin
            state_r    <= IDLE;
            kind_r     <= 2'b00;
            addr_r     <= '0;
            data_r     <= '0;
            pc_r       <= '0;
            sp_r       <= '0;
            mem_addr_r <= '0;
            mem_data_r <= '0;
            mem_we_r   <= 1'b0;
            sp_out_r   <= '0;
            sp_we_r    <= 1'b0;
            done_r     <= 1'b0;
            ready_r    <= 1'b1;
        end else begin
            state_r    <= state_n_s;
            kind_r     <= kind_n_s;
            addr_r     <= addr_n_s;
            data_r     <= data_n_s;
            pc_r       <= pc_n_s;
            sp_r       <= sp_n_s;
            mem_addr_r <= mem_addr_n_s;
            mem_data_r <= mem_data_n_s;
            mem_we_r   <= mem_we_n_s;
            sp_out_r   <= sp_out_n_s;
            sp_we_r    <= sp_we_n_s;
            done_r     <= done_n_s;
            ready_r    <= (state_n_s == IDLE);
        end
    end

    assign req_ready = ready_r;
    assign busy      = ~ready_r;
    assign mem_addr  = mem_addr_r;
    assign mem_data  = mem_data_r;
    assign mem_we    = mem_we_r;
    assign sp_out    = sp_out_r;
    assign sp_we     = sp_we_r;
    assign done      = done_r;

endmodule

// File: tb/tb_store_unit.sv
// Self-checking bench for store_unit: directed scenarios plus random requests
// checked against a byte-list reference model of each request.
module tb_store_unit;

    logic        phi1;
    logic        reset_n;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_kind;
    logic [15:0] req_addr;
    logic [7:0]  req_data;
    logic [15:0] req_pc;
    logic [7:0]  sp_in;
    logic [15:0] mem_addr;
    logic [7:0]  mem_data;
    logic        mem_we;
    logic [7:0]  sp_out;
    logic        sp_we;
    logic        done;
    logic        busy;

    int n_assert = 0;
    int n_fail   = 0;

    store_unit dut (
        .phi1(phi1), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_kind(req_kind),
        .req_addr(req_addr), .req_data(req_data), .req_pc(req_pc), .sp_in(sp_in),
        .mem_addr(mem_addr), .mem_data(mem_data), .mem_we(mem_we),
        .sp_out(sp_out), .sp_we(sp_we), .done(done), .busy(busy)
    );

    initial begin
        phi1 = 1'b0;
        forever #5 phi1 = ~phi1;
    end

    task automatic tick();
        @(posedge phi1);
        @(negedge phi1);
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_write(input string tag, input logic [15:0] a, input logic [7:0] d,
                               input logic last, input logic spwe, input logic [7:0] spv);
        check({tag, " mem_we"},    32'(mem_we),    32'd1);
        check({tag, " mem_addr"},  32'(mem_addr),  32'(a));
        check({tag, " mem_data"},  32'(mem_data),  32'(d));
        check({tag, " done"},      32'(done),      32'(last));
        check({tag, " sp_we"},     32'(sp_we),     32'(spwe));
        if (spwe) check({tag, " sp_out"}, 32'(sp_out), 32'(spv));
        check({tag, " req_ready"}, 32'(req_ready), 32'd0);
        check({tag, " busy"},      32'(busy),      32'd1);
    endtask

    task automatic check_idle(input string tag);
        check({tag, " idle mem_we"},    32'(mem_we),    32'd0);
        check({tag, " idle done"},      32'(done),      32'd0);
        check({tag, " idle sp_we"},     32'(sp_we),     32'd0);
        check({tag, " idle req_ready"}, 32'(req_ready), 32'd1);
        check({tag, " idle busy"},      32'(busy),      32'd0);
    endtask

    // Reference: list of bytes a request writes and the SP it leaves behind.
    task automatic model(input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] data,
                         input logic [15:0] pc, input logic [7:0] sp, output int n,
                         output logic [2:0][15:0] ea, output logic [2:0][7:0] ed,
                         output logic [7:0] sp_new);
        logic [2:0][7:0] bytes;
        int nbytes [4] = '{1, 1, 2, 3};
        n = nbytes[kind];
        bytes[0] = (kind == 2'd1) ? data : 8'(pc / 256);
        bytes[1] = 8'(pc % 256);
        bytes[2] = data;
        for (int i = 0; i < 3; i++) begin
            ea[i] = 16'(256 + ((int'(sp) - i + 256) % 256));
            ed[i] = bytes[i];
        end
        if (kind == 2'd0) begin
            ea[0] = addr;
            ed[0] = data;
        end
        sp_new = 8'((int'(sp) - n + 256) % 256);
    endtask

    task automatic drive(input logic [1:0] kind, input logic [15:0] addr, input logic [7:0] data,
                         input logic [15:0] pc, input logic [7:0] sp);
        req_valid = 1'b1;
        req_kind  = kind;
        req_addr  = addr;
        req_data  = data;
        req_pc    = pc;
        sp_in     = sp;
    endtask

    task automatic scramble();
        req_kind = 2'($urandom);
        req_addr = 16'($urandom);
        req_data = 8'($urandom);
        req_pc   = 16'($urandom);
        sp_in    = 8'($urandom);
    endtask

    // Issue one request from IDLE and check every write cycle plus the following idle cycle.
    task automatic run_req(input string tag, input logic [1:0] kind, input logic [15:0] addr,
                           input logic [7:0] data, input logic [15:0] pc, input logic [7:0] sp);
        int n;
        logic [2:0][15:0] ea;
        logic [2:0][7:0] ed;
        logic [7:0] spn;
        model(kind, addr, data, pc, sp, n, ea, ed, spn);
        drive(kind, addr, data, pc, sp);
        tick();
        req_valid = 1'b0;
        scramble();
        for (int i = 0; i < n; i++) begin
            check_write(tag, ea[i], ed[i], i == n - 1, (i == n - 1) && (kind != 2'd0), spn);
            tick();
        end
        check_idle(tag);
    endtask

    initial begin
        logic [1:0] rk;
        int waited;
        reset_n = 1'b0;
        drive(2'd0, 16'h1111, 8'h22, 16'h3333, 8'h44);
        tick();
        check("reset1 mem_we", 32'(mem_we), 32'd0);
        tick();
        check("reset2 mem_we", 32'(mem_we), 32'd0);
        req_valid = 1'b0;
        reset_n   = 1'b1;
        tick();
        check_idle("reset");
        check("reset mem_addr", 32'(mem_addr), 32'd0);
        check("reset mem_data", 32'(mem_data), 32'd0);
        check("reset sp_out",   32'(sp_out),   32'd0);

        run_req("store",  2'd0, 16'h0234, 8'hA5, 16'h0000, 8'h10);
        run_req("brk",    2'd3, 16'h0000, 8'h34, 16'hC123, 8'hFF);
        run_req("spwrap", 2'd3, 16'h0000, 8'h5A, 16'h1234, 8'h01);
        run_req("push1w", 2'd1, 16'h0000, 8'h99, 16'h0000, 8'h00);
        run_req("push2w", 2'd2, 16'h0000, 8'h00, 16'hBEEF, 8'h00);

        // PUSH2 with a STORE presented while busy; the STORE waits for req_ready.
        drive(2'd2, 16'h0000, 8'h00, 16'hABCD, 8'h80);
        tick();
        drive(2'd0, 16'h0555, 8'h77, 16'h0000, 8'h11);
        check_write("busy w1", 16'h0180, 8'hAB, 1'b0, 1'b0, 8'h00);
        tick();
        check_write("busy w2", 16'h017F, 8'hCD, 1'b1, 1'b1, 8'h7E);
        tick();
        check_idle("busy gap");
        waited = 0;
        while (req_ready !== 1'b1 && waited < 10) begin
            tick();
            waited++;
        end
        check("busy ready bound", 32'(req_ready), 32'd1);
        tick();
        req_valid = 1'b0;
        check_write("busy store", 16'h0555, 8'h77, 1'b1, 1'b0, 8'h00);
        tick();
        check_idle("busy store");

        // Reset after the first byte of a PUSH2 abandons the rest.
        drive(2'd2, 16'h0000, 8'h00, 16'h5678, 8'h40);
        tick();
        req_valid = 1'b0;
        check_write("abort w1", 16'h0140, 8'h56, 1'b0, 1'b0, 8'h00);
        reset_n = 1'b0;
        tick();
        check("abort mem_we",    32'(mem_we),    32'd0);
        check("abort sp_we",     32'(sp_we),     32'd0);
        check("abort done",      32'(done),      32'd0);
        check("abort req_ready", 32'(req_ready), 32'd1);
        check("abort mem_addr",  32'(mem_addr),  32'd0);
        reset_n = 1'b1;
        tick();
        check_idle("abort after");

        for (int k = 0; k < 40; k++) begin
            rk = 2'($urandom);
            run_req("rand", rk, 16'($urandom), 8'($urandom), 16'($urandom), 8'($urandom));
            if ($urandom_range(0, 1) == 0) begin
                tick();
                check_idle("rand gap");
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
